// File: rtl/expr_recognizer_if.sv
// Character-stream interface of the expression recognizer.
//   en     : character valid; consumed on a rising edge with en=1
//   in     : W-bit character code
//   out    : 1 = consumed prefix is a complete legal expression
//   err    : 1 = recognizer is in its ILLEGAL state
//   depth  : current open-parenthesis count
//   nops   : number of operands started, saturating at 255
// The master drives the characters; the slave (the recognizer) returns status.
interface expr_recognizer_if #(
    parameter int unsigned W = 8
);
    logic         en;
    logic [W-1:0] in;
    logic         out;
    logic         err;
    logic [3:0]   depth;
    logic [7:0]   nops;

    modport master (output en, in, input  out, err, depth, nops);
    modport slave  (input  en, in, output out, err, depth, nops);
endinterface

// File: rtl/expr_recognizer.sv
// Registered recognizer for arithmetic expressions fed one character per
// enabled clock. Operands are multi-digit decimal numbers, operators come
// from OP_MASK, and parentheses nest up to MAX_DEPTH. With STICKY=0 a ';'
// restarts recognition from any state, including ILLEGAL.
// Ports:
//   clk    : system clock, rising edge
//   clr_n  : asynchronous active-low reset
//   bus    : slave side of expr_recognizer_if (en/in in, out/err/depth/nops out)
module expr_recognizer #(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_DEPTH = 4,
    parameter logic [3:0]  OP_MASK   = 4'b0011,
    parameter bit          STICKY    = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    expr_recognizer_if.slave bus
);
    typedef enum logic [1:0] {
        S_START   = 2'd0,
        S_NUM     = 2'd1,
        S_CLOSE   = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_depth, w_depth_nxt;
    logic [7:0] r_nops,  w_nops_nxt;
    logic       r_out,   w_out_nxt;
    logic       r_err,   w_err_nxt;

    logic w_digit, w_op, w_lp, w_rp, w_term;
    logic w_can_open, w_can_close;

    // Full-width compares: any bit set above bit 7 makes the character "other".
    assign w_digit = (bus.in >= W'(48)) && (bus.in <= W'(57));
    assign w_op    = (OP_MASK[0] && (bus.in == W'(43)))
                  || (OP_MASK[1] && (bus.in == W'(42)))
                  || (OP_MASK[2] && (bus.in == W'(45)))
                  || (OP_MASK[3] && (bus.in == W'(47)));
    assign w_lp    = (bus.in == W'(40));
    assign w_rp    = (bus.in == W'(41));
    // With STICKY=1 ';' is an ordinary "other" character.
    assign w_term  = !STICKY && (bus.in == W'(59));

    assign w_can_open  = (r_depth < 4'(MAX_DEPTH));
    assign w_can_close = (r_depth != 4'd0);

    // State register. Status outputs are registered from the next-state
    // values so they describe the prefix including the character just taken.
    always_ff @(posedge clk or negedge clr_n) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so the update order inside this block is irrelevant.
        if (!clr_n) begin
            r_state <= S_START;
            r_depth <= 4'd0;
            r_nops  <= 8'd0;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.en) begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            r_nops  <= w_nops_nxt;
            r_out   <= w_out_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic. depth and nops default to holding, which also gives
    // the freeze-on-ILLEGAL behaviour for free.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_nops_nxt  = r_nops;
        if (w_term) begin
            w_state_nxt = S_START;
            w_depth_nxt = 4'd0;
            w_nops_nxt  = 8'd0;
        end else begin
            case (r_state)
                S_START: begin
                    if (w_digit) begin
                        w_state_nxt = S_NUM;
                        w_nops_nxt  = (r_nops == 8'hFF) ? r_nops : r_nops + 8'd1;
                    end else if (w_lp && w_can_open) begin
                        w_depth_nxt = r_depth + 4'd1;
                    end else begin
                        w_state_nxt = S_ILLEGAL;
                    end
                end
                S_NUM: begin
                    if (w_digit) begin
                        w_state_nxt = S_NUM;
                    end else if (w_op) begin
                        w_state_nxt = S_START;
                    end else if (w_rp && w_can_close) begin
                        w_state_nxt = S_CLOSE;
                        w_depth_nxt = r_depth - 4'd1;
                    end else begin
                        w_state_nxt = S_ILLEGAL;
                    end
                end
                S_CLOSE: begin
                    if (w_op) begin
                        w_state_nxt = S_START;
                    end else if (w_rp && w_can_close) begin
                        w_depth_nxt = r_depth - 4'd1;
                    end else begin
                        w_state_nxt = S_ILLEGAL;
                    end
                end
                S_ILLEGAL: w_state_nxt = S_ILLEGAL;
                default: begin
                    w_state_nxt = S_START;
                    w_depth_nxt = 4'd0;
                end
            endcase
        end
    end

    // Output logic: decoded from the next state so out/err are mutually exclusive.
    always_comb begin
        w_out_nxt = ((w_state_nxt == S_NUM) || (w_state_nxt == S_CLOSE))
                 && (w_depth_nxt == 4'd0);
        w_err_nxt = (w_state_nxt == S_ILLEGAL);
    end

    assign bus.out   = r_out;
    assign bus.err   = r_err;
    assign bus.depth = r_depth;
    assign bus.nops  = r_nops;
endmodule
